seg_display_mux: RTL and testbench

- Downstream stage of the four-digit LED decoder.
- Takes the four 8-bit segment patterns (LED1..LED4) and time-multiplexes them onto one segment bus with one-hot digit (anode) selects, for boards with a shared-segment 4-digit display.
- Snapshots inputs once per frame so a digit never tears mid-frame.
- Inserts one blank (dead-time) cycle per digit slot to suppress ghosting.

---
 rtl/seg_display_mux.sv | 82 ++++++++
 tb/tb_seg_display_mux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Time-multiplexes four 8-bit segment patterns onto one shared segment bus with
// one-hot digit selects, a per-frame input snapshot and one blank cycle per digit slot.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV      = 4,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter logic [0:7]  SEG_OFF          = 8'hFF
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       En,
  input  logic [0:7] LED1,
  input  logic [0:7] LED2,
  input  logic [0:7] LED3,
  input  logic [0:7] LED4,
  output logic [0:7] SEG,
  output logic [3:0] AN,
  output logic [1:0] Digit_Sel,
  output logic       Frame_Tick
);

  localparam int unsigned   CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0]    AN_OFF  = ANODE_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [0:7]    shadow [4];
  logic          primed;

  logic       slot_end;
  logic       frame_wrap;
  logic       load;
  logic [3:0] an_lit;

  // NOTE: every signal written in always_comb gets a value on every path (here
  // unconditionally); a missed path would infer a latch.
  always_comb begin
    slot_end   = (cnt == CNT_MAX);
    frame_wrap = En && slot_end && (idx == 2'd3);
    load       = En && (!primed || frame_wrap);
    // Flipping one bit of the idle pattern yields the lit select for either polarity.
    an_lit     = AN_OFF ^ (4'b0001 << idx);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; outputs below are deliberately computed from the old cnt/idx/shadow.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt        <= '0;
      idx        <= '0;
      primed     <= 1'b0;
      SEG        <= SEG_OFF;
      AN         <= AN_OFF;
      Digit_Sel  <= '0;
      Frame_Tick <= 1'b0;
      // NOTE: the snapshot registers are reset (only four of them) so the display
      // shows a defined blank pattern rather than X before the first priming load.
      for (int i = 0; i < 4; i++) shadow[i] <= SEG_OFF;
    end else begin
      if (En) begin
        cnt        <= slot_end ? '0 : cnt + 1'b1;
        idx        <= slot_end ? idx + 2'd1 : idx;
        SEG        <= (cnt == '0) ? SEG_OFF : shadow[idx];
        AN         <= (cnt == '0) ? AN_OFF : an_lit;
        Frame_Tick <= frame_wrap;
      end else begin
        SEG        <= SEG_OFF;
        AN         <= AN_OFF;
        Frame_Tick <= 1'b0;
      end
      Digit_Sel <= idx;
      if (load) begin
        shadow[0] <= LED1;
        shadow[1] <= LED2;
        shadow[2] <= LED3;
        shadow[3] <= LED4;
        primed    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: a fixed vector table for reset and the first
// frame, hand sequences for snapshot/enable/reset corners, then randomized model checks.
module tb_seg_display_mux;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       En;
  logic [0:7] led [4];

  logic [0:7] seg0, seg1;
  logic [3:0] an0, an1;
  logic [1:0] dsel0, dsel1;
  logic       tick0, tick1;

  always #5 CLK = ~CLK;

  seg_display_mux dut (
    .CLK(CLK), .Reset(Reset), .En(En),
    .LED1(led[0]), .LED2(led[1]), .LED3(led[2]), .LED4(led[3]),
    .SEG(seg0), .AN(an0), .Digit_Sel(dsel0), .Frame_Tick(tick0)
  );

  seg_display_mux #(.REFRESH_DIV(2), .ANODE_ACTIVE_LOW(1'b0), .SEG_OFF(8'hFF)) dut2 (
    .CLK(CLK), .Reset(Reset), .En(En),
    .LED1(led[0]), .LED2(led[1]), .LED3(led[2]), .LED4(led[3]),
    .SEG(seg1), .AN(an1), .Digit_Sel(dsel1), .Frame_Tick(tick1)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: position within the frame as a plain integer 0..4*D-1.
  int         m_pos    [2];
  logic [7:0] m_sh     [2][4];
  bit         m_primed [2];
  logic [7:0] e_seg    [2];
  logic [3:0] e_an     [2];
  logic [1:0] e_dsel   [2];
  bit         e_tick   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int d;
    int digit;
    logic [3:0] off;
    logic [3:0] onehot;
    d      = (k == 0) ? 4 : 2;
    off    = (k == 0) ? 4'b1111 : 4'b0000;
    digit  = m_pos[k] / d;
    onehot = 4'(1 << digit);
    if (!Reset) begin
      m_pos[k] = 0; m_primed[k] = 0;
      for (int i = 0; i < 4; i++) m_sh[k][i] = 8'hFF;
      e_seg[k] = 8'hFF; e_an[k] = off; e_dsel[k] = 0; e_tick[k] = 0;
    end else if (!En) begin
      e_seg[k] = 8'hFF; e_an[k] = off; e_tick[k] = 0; e_dsel[k] = 2'(digit);
    end else begin
      e_dsel[k] = 2'(digit);
      e_tick[k] = (m_pos[k] == 4*d - 1);
      if (m_pos[k] % d == 0) begin
        e_seg[k] = 8'hFF; e_an[k] = off;
      end else begin
        e_seg[k] = m_sh[k][digit];
        e_an[k]  = (k == 0) ? ~onehot : onehot;
      end
      if (!m_primed[k] || m_pos[k] == 4*d - 1) begin
        for (int i = 0; i < 4; i++) m_sh[k][i] = led[i];
        m_primed[k] = 1;
      end
      m_pos[k] = (m_pos[k] + 1) % (4*d);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    check("seg0",  32'(seg0),  32'(e_seg[0]));
    check("an0",   32'(an0),   32'(e_an[0]));
    check("dsel0", 32'(dsel0), 32'(e_dsel[0]));
    check("tick0", 32'(tick0), 32'(e_tick[0]));
    check("seg1",  32'(seg1),  32'(e_seg[1]));
    check("an1",   32'(an1),   32'(e_an[1]));
    check("dsel1", 32'(dsel1), 32'(e_dsel[1]));
    check("tick1", 32'(tick1), 32'(e_tick[1]));
  endtask

  task automatic advance_to(input int target);
    int n;
    n  = 0;
    En = 1'b1;
    while (m_pos[0] != target && n < 64) begin
      tick();
      n++;
    end
    if (m_pos[0] != target) begin
      n_vec++;
      n_bad++;
      $display("FAIL advance_to: position %0d not reached (at %0d)", target, m_pos[0]);
    end
  endtask

  typedef struct {
    bit         rst_n;
    bit         en;
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] dsel;
    bit         ftick;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(bit r, bit e, logic [7:0] s, logic [3:0] a, logic [1:0] d, bit t);
    vec_t v;
    v.rst_n = r; v.en = e; v.seg = s; v.an = a; v.dsel = d; v.ftick = t;
    return v;
  endfunction

  initial begin
    Reset = 1'b0;
    En    = 1'b1;
    led[0] = 8'h03; led[1] = 8'h9F; led[2] = 8'h25; led[3] = 8'h0D;

    for (int i = 0; i < 3; i++) tbl[i] = mk(0, 1, 8'hFF, 4'b1111, 0, 0);
    tbl[3]  = mk(1, 1, 8'hFF, 4'b1111, 0, 0);
    for (int i = 4; i < 7; i++)   tbl[i] = mk(1, 1, 8'h03, 4'b1110, 0, 0);
    tbl[7]  = mk(1, 1, 8'hFF, 4'b1111, 1, 0);
    for (int i = 8; i < 11; i++)  tbl[i] = mk(1, 1, 8'h9F, 4'b1101, 1, 0);
    tbl[11] = mk(1, 1, 8'hFF, 4'b1111, 2, 0);
    for (int i = 12; i < 15; i++) tbl[i] = mk(1, 1, 8'h25, 4'b1011, 2, 0);
    tbl[15] = mk(1, 1, 8'hFF, 4'b1111, 3, 0);
    tbl[16] = mk(1, 1, 8'h0D, 4'b0111, 3, 0);
    tbl[17] = mk(1, 1, 8'h0D, 4'b0111, 3, 0);
    tbl[18] = mk(1, 1, 8'h0D, 4'b0111, 3, 1);
    tbl[19] = mk(1, 1, 8'hFF, 4'b1111, 0, 0);

    for (int i = 0; i < 20; i++) begin
      Reset = tbl[i].rst_n;
      En    = tbl[i].en;
      tick();
      check($sformatf("tbl%0d_seg", i),  32'(seg0),  32'(tbl[i].seg));
      check($sformatf("tbl%0d_an", i),   32'(an0),   32'(tbl[i].an));
      check($sformatf("tbl%0d_dsel", i), 32'(dsel0), 32'(tbl[i].dsel));
      check($sformatf("tbl%0d_tick", i), 32'(tick0), 32'(tbl[i].ftick));
    end

    // Input change mid-frame only takes effect after the next frame wrap.
    advance_to(9);
    led[0] = 8'h4F;
    advance_to(13);
    tick();
    check("snap_digit3_old", 32'(seg0), 32'h0D);
    advance_to(1);
    tick();
    check("snap_digit0_new", 32'(seg0), 32'h4F);
    check("snap_digit0_an",  32'(an0),  32'b1110);
    led[1] = 8'h11;
    advance_to(5);
    tick();
    check("snap_digit1_held", 32'(seg0), 32'h9F);

    // Enable gap at digit 2, cnt 3 pending.
    advance_to(11);
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_an",   32'(an0),   32'b1111);
      check("gap_dsel", 32'(dsel0), 32'd2);
    end
    En = 1'b1;
    tick();
    check("resume_seg", 32'(seg0), 32'h25);
    check("resume_an",  32'(an0),  32'b1011);
    tick();
    check("resume_blank_an", 32'(an0),   32'b1111);
    check("resume_dsel",     32'(dsel0), 32'd3);

    // Reset mid-frame while digit 3 is lit, then restart with fresh values.
    advance_to(13);
    led[0] = 8'h12; led[1] = 8'h34; led[2] = 8'h56; led[3] = 8'h78;
    Reset = 1'b0;
    tick();
    check("rst_seg",  32'(seg0),  32'hFF);
    check("rst_an",   32'(an0),   32'b1111);
    check("rst_tick", 32'(tick0), 32'd0);
    Reset = 1'b1;
    tick();
    check("restart_blank", 32'(an0), 32'b1111);
    check("restart_an2",   32'(an1), 32'b0000);
    tick();
    check("restart_seg", 32'(seg0), 32'h12);
    check("restart_an",  32'(an0),  32'b1110);
    check("dut2_lit_an", 32'(an1),  32'b0001);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(199) != 0);
      En    = ($urandom_range(7) != 0);
      if ($urandom_range(3) == 0) led[$urandom_range(3)] = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
